spi_audio_master: RTL and testbench

SPI master that drives the speech-recognition slave from the host side. It streams a burst of 10-bit audio samples as 32-bit words, reads back one 32-bit result word, and optionally echoes that word back so the slave can confirm it. One `clk` domain; `sck` is generated internally by dividing `clk`.

---
 rtl/spi_audio_master.sv | 219 +++++++++++++++++++++
 tb/tb_spi_audio_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_audio_master.sv
// spi_audio_master
//   SPI master on the host side of the speech-recognition link. It streams
//   NUM_WORDS audio samples as 32-bit words {22'b0, sample} in one ss frame,
//   then reads back one 32-bit result word in a second frame. Optionally it
//   echoes the result word in a third frame.
//   sck is clk / (2*CLK_DIV) and idles low. Data is MSB first. sdo changes
//   only after sck falls, and sdi is captured on the clk edge where sck rises.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   start                 one-cycle pulse that begins a transaction from IDLE
//   sample, sample_valid  audio sample source
//   sample_ready          accepts the sample this cycle (valid & ready)
//   sdi                   serial data from the slave
//   sck, sdo, ss          SPI clock, serial data out, active-high slave select
//   busy                  high while a transaction is in progress
//   result, result_valid  word read back from the slave, with a one-cycle strobe
//   done                  one-cycle pulse at the end of the transaction
//
// Build option
//   SPI_RESULT_ECHO_EN    when defined, the result word is echoed in a third frame
module spi_audio_master #(
  parameter int unsigned NUM_WORDS  = 1000,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  sample,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        sdi,
  output logic        sck,
  output logic        sdo,
  output logic        ss,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        done
);

  localparam int unsigned WCW = $clog2(NUM_WORDS + 1);
  localparam int unsigned DW  = $clog2(CLK_DIV + 1);
  localparam int unsigned GW  = $clog2(GAP_CYCLES + 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS);
  localparam logic [DW-1:0]  DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0]  GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, AUD_LOAD, AUD_SHIFT, GAP1, RX_SHIFT, GAP2, ECHO_SHIFT, DONE
  } state_t;

  state_t         state_q, state_d;
  logic           sck_q, sck_d;
  logic           ss_q, ss_d;
  logic           rv_q, rv_d;
  logic [31:0]    tx_q, tx_d;
  logic [31:0]    rx_q, rx_d;
  logic [31:0]    result_q, result_d;
  logic [4:0]     bit_q, bit_d;
  logic [DW-1:0]  div_q, div_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [WCW-1:0] word_q, word_d;

  logic           shifting;
  logic           frame_end;
  logic [WCW-1:0] word_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sck_q    <= 1'b0;
      ss_q     <= 1'b0;
      rv_q     <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      result_q <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      gap_q    <= '0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      sck_q    <= sck_d;
      ss_q     <= ss_d;
      rv_q     <= rv_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      result_q <= result_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      gap_q    <= gap_d;
      word_q   <= word_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sck_d        = sck_q;
    ss_d         = ss_q;
    rv_d         = 1'b0;
    tx_d         = tx_q;
    rx_d         = rx_q;
    result_d     = result_q;
    bit_d        = bit_q;
    div_d        = div_q;
    gap_d        = gap_q;
    word_d       = word_q;
    sample_ready = 1'b0;
    frame_end    = 1'b0;
    word_inc     = word_q + 1'b1;
    shifting     = (state_q == AUD_SHIFT) || (state_q == RX_SHIFT) ||
                   (state_q == ECHO_SHIFT);

    // Shared bit engine for all three frame types. sdo is tx_q[31], so the
    // shift on every falling edge (including the last one) both advances the
    // next bit and leaves sdo at 0 once the frame is over.
    if (shifting) begin
      div_d = div_q + 1'b1;
      if (div_q == DIV_LAST) begin
        div_d = '0;
        sck_d = ~sck_q;
        if (!sck_q) begin
          rx_d = {rx_q[30:0], sdi};
        end else begin
          tx_d = {tx_q[30:0], 1'b0};
          if (bit_q == 5'd31) frame_end = 1'b1;
          else                bit_d     = bit_q + 5'd1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = AUD_LOAD;
          ss_d    = 1'b1;
          word_d  = '0;
        end
      end
      AUD_LOAD: begin
        sample_ready = sample_valid;
        if (sample_valid) begin
          tx_d    = {22'b0, sample};
          bit_d   = '0;
          div_d   = '0;
          state_d = AUD_SHIFT;
        end
      end
      AUD_SHIFT: begin
        if (frame_end) begin
          word_d = word_inc;
          if (word_inc == LAST_WORD) begin
            ss_d    = 1'b0;
            gap_d   = '0;
            state_d = GAP1;
          end else begin
            state_d = AUD_LOAD;
          end
        end
      end
      GAP1: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          ss_d    = 1'b1;
          tx_d    = '0;
          bit_d   = '0;
          div_d   = '0;
          state_d = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        if (frame_end) begin
          result_d = rx_q;
          rv_d     = 1'b1;
          ss_d     = 1'b0;
          gap_d    = '0;
          state_d  = GAP2;
        end
      end
      GAP2: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
`ifdef SPI_RESULT_ECHO_EN
          ss_d    = 1'b1;
          tx_d    = result_q;
          bit_d   = '0;
          div_d   = '0;
          state_d = ECHO_SHIFT;
`else
          state_d = DONE;
`endif
        end
      end
      ECHO_SHIFT: begin
        if (frame_end) begin
          ss_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sck          = sck_q;
  assign sdo          = tx_q[31];
  assign ss           = ss_q;
  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign result_valid = rv_q;
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_spi_audio_master.sv
`timescale 1ns/1ps
module tb_spi_audio_master;

  localparam int NW     = 4;
  localparam int CD     = 2;
  localparam int GC     = 16;
  localparam int BUDGET = 3000;
`ifdef SPI_RESULT_ECHO_EN
  localparam int EXP_FRAMES   = 3;
  localparam int EXP_GAPS     = 2;
  localparam int EXP_DONE_GAP = 0;
`else
  localparam int EXP_FRAMES   = 2;
  localparam int EXP_GAPS     = 1;
  localparam int EXP_DONE_GAP = 16;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  sample = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        sdi = 1'b0;
  logic        sck, sdo, ss, busy, result_valid, done;
  logic [31:0] result;

  logic [31:0] resp = 32'h0000_1111;
  logic [9:0]  samples [4] = '{10'h3FF, 10'h000, 10'h2AA, 10'h155};

  int comps = 0, errs = 0;
  int frames = 0, aud_rises = 0, rises_noss = 0, done_cnt = 0, rv_cnt = 0;
  int hs_cnt = 0, words_seen = 0, nb = 0, txn_frame = 0, low_run = 0, done_gap = -1;
  logic ss_p = 1'b0, sck_p = 1'b0;
  logic [31:0] sh = '0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          gap_q[$];

  spi_audio_master #(.NUM_WORDS(NW), .CLK_DIV(CD), .GAP_CYCLES(GC)) dut (
    .clk(clk), .reset(reset), .start(start), .sample(sample),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sdi(sdi),
    .sck(sck), .sdo(sdo), .ss(ss), .busy(busy), .result(result),
    .result_valid(result_valid), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sample_valid && sample_ready) hs_cnt++;

  // Slave model and bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      nb = 0; txn_frame = 0; low_run = 0; sdi = 1'b0;
    end else begin
      if (!busy) begin txn_frame = 0; low_run = 0; end
      if (ss && !ss_p) begin
        txn_frame++; frames++; nb = 0;
        if (low_run > 0) gap_q.push_back(low_run);
        low_run = 0;
        sdi = (txn_frame == 2) ? resp[31] : 1'b0;
      end
      if (busy && !ss && !done) low_run++;
      if (done) begin done_cnt++; done_gap = low_run; end
      if (result_valid) rv_cnt++;
      if (sck && !sck_p) begin
        if (ss) begin
          sh = {sh[30:0], sdo}; nb++;
          if (txn_frame == 1) aud_rises++;
          if (nb == 32) begin got_q.push_back(sh); words_seen++; nb = 0; end
        end else rises_noss++;
      end
      if (!sck && sck_p && ss && txn_frame == 2) sdi = resp[31-nb];
    end
    ss_p = ss; sck_p = sck;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic push_tail();
    exp_q.push_back(32'h0);
`ifdef SPI_RESULT_ECHO_EN
    exp_q.push_back(resp);
`endif
  endtask

  task automatic feed(input int n, input int stall_at, input int stall_len, output int stall_bad);
    int w0, k;
    w0 = words_seen; stall_bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        sample_valid = 1'b0;
        k = 0;
        while (!((words_seen - w0) >= stall_at && !sck) && k < BUDGET) begin
          @(negedge clk); #1; k++;
        end
        if (k >= BUDGET) begin
          comps++; errs++;
          $display("FAIL stall_wait: timed out after %0d cycles, required word %0d done", k, stall_at);
        end
        for (int c = 0; c < stall_len; c++) begin
          if (!ss || sck || sample_ready || !busy) stall_bad++;
          @(negedge clk); #1;
        end
      end
      sample = samples[i]; sample_valid = 1'b1;
      exp_q.push_back({22'b0, samples[i]});
      #1; k = 0;
      while (!sample_ready && k < BUDGET) begin @(negedge clk); #1; k++; end
      if (k >= BUDGET) begin
        comps++; errs++;
        $display("FAIL handshake_wait: no sample_ready for word %0d after %0d cycles", i, k);
        sample_valid = 1'b0;
        return;
      end
      @(posedge clk); @(negedge clk);
    end
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 4 * BUDGET) begin @(negedge clk); #1; k++; end
    if (k >= 4 * BUDGET) begin
      comps++; errs++;
      $display("FAIL done_wait: no done after %0d cycles", k);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    comps++; if (ss !== 1'b0)           begin errs++; $display("FAIL rst_ss: got %b want 0", ss); end
    comps++; if (sck !== 1'b0)          begin errs++; $display("FAIL rst_sck: got %b want 0", sck); end
    comps++; if (sdo !== 1'b0)          begin errs++; $display("FAIL rst_sdo: got %b want 0", sdo); end
    comps++; if (busy !== 1'b0)         begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
    comps++; if (result !== 32'h0)      begin errs++; $display("FAIL rst_result: got %h want 0", result); end
    comps++; if (result_valid !== 1'b0) begin errs++; $display("FAIL rst_rv: got %b want 0", result_valid); end
    comps++; if (done !== 1'b0)         begin errs++; $display("FAIL rst_done: got %b want 0", done); end
    comps++; if (sample_ready !== 1'b0) begin errs++; $display("FAIL rst_ready: got %b want 0", sample_ready); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_burst();
    int h0, f0, a0, n0, d0, r0, sb;
    logic [31:0] g, e;
    h0 = hs_cnt; f0 = frames; a0 = aud_rises; n0 = rises_noss; d0 = done_cnt; r0 = rv_cnt;
    gap_q.delete();
    pulse_start();
    feed(NW, -1, 0, sb);
    push_tail();
    pulse_start();  // ignored while busy
    wait_done(d0);
    repeat (40) @(negedge clk);
    #1;
    comps++; if (hs_cnt - h0 !== NW) begin errs++; $display("FAIL burst_hs: got %0d want %0d", hs_cnt - h0, NW); end
    comps++; if (got_q.size() !== exp_q.size()) begin errs++; $display("FAIL burst_nwords: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      comps++; if (g !== e) begin errs++; $display("FAIL burst_word: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    comps++; if (aud_rises - a0 !== 32 * NW) begin errs++; $display("FAIL burst_rises: got %0d want %0d", aud_rises - a0, 32 * NW); end
    comps++; if (rises_noss - n0 !== 0) begin errs++; $display("FAIL burst_sck_no_ss: got %0d want 0", rises_noss - n0); end
    comps++; if (frames - f0 !== EXP_FRAMES) begin errs++; $display("FAIL burst_frames: got %0d want %0d", frames - f0, EXP_FRAMES); end
    comps++; if (gap_q.size() !== EXP_GAPS) begin errs++; $display("FAIL burst_ngaps: got %0d want %0d", gap_q.size(), EXP_GAPS); end
    while (gap_q.size() > 0) begin
      int gl;
      gl = gap_q.pop_front();
      comps++; if (gl !== GC) begin errs++; $display("FAIL burst_gap_len: got %0d want %0d", gl, GC); end
    end
    comps++; if (done_gap !== EXP_DONE_GAP) begin errs++; $display("FAIL burst_done_gap: got %0d want %0d", done_gap, EXP_DONE_GAP); end
    comps++; if (done_cnt - d0 !== 1) begin errs++; $display("FAIL burst_done_cnt: got %0d want 1", done_cnt - d0); end
    comps++; if (rv_cnt - r0 !== 1) begin errs++; $display("FAIL burst_rv_cnt: got %0d want 1", rv_cnt - r0); end
    comps++; if (result !== resp) begin errs++; $display("FAIL burst_result: got %h want %h", result, resp); end
    comps++; if (busy !== 1'b0) begin errs++; $display("FAIL burst_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_stall();
    int h0, d0, sb;
    logic [31:0] g, e;
    h0 = hs_cnt; d0 = done_cnt;
    pulse_start();
    feed(NW, 2, 50, sb);
    push_tail();
    wait_done(d0);
    repeat (5) @(negedge clk);
    #1;
    comps++; if (sb !== 0) begin errs++; $display("FAIL stall_hold: %0d bad cycles want 0", sb); end
    comps++; if (hs_cnt - h0 !== NW) begin errs++; $display("FAIL stall_hs: got %0d want %0d", hs_cnt - h0, NW); end
    comps++; if (got_q.size() !== exp_q.size()) begin errs++; $display("FAIL stall_nwords: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      comps++; if (g !== e) begin errs++; $display("FAIL stall_word: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    comps++; if (done_cnt - d0 !== 1) begin errs++; $display("FAIL stall_done_cnt: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int h0, d0, r0, k, w0, sb;
    logic [31:0] g, e;
    d0 = done_cnt; r0 = rv_cnt; w0 = words_seen;
    pulse_start();
    feed(3, -1, 0, sb);
    k = 0;
    while (!((words_seen - w0) == 2 && nb == 17) && k < BUDGET) begin @(negedge clk); #1; k++; end
    if (k >= BUDGET) begin
      comps++; errs++;
      $display("FAIL rmid_wait: bit 17 of word 3 not reached after %0d cycles", k);
    end
    reset = 1'b1;
    @(negedge clk); #1;
    comps++; if (ss !== 1'b0)   begin errs++; $display("FAIL rmid_ss: got %b want 0", ss); end
    comps++; if (sck !== 1'b0)  begin errs++; $display("FAIL rmid_sck: got %b want 0", sck); end
    comps++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_busy: got %b want 0", busy); end
    comps++; if (result !== 32'h0) begin errs++; $display("FAIL rmid_result: got %h want 0", result); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    comps++; if (rv_cnt - r0 !== 0 || done_cnt - d0 !== 0) begin
      errs++; $display("FAIL rmid_pulses: rv %0d done %0d want 0 0", rv_cnt - r0, done_cnt - d0);
    end
    for (int i = 0; i < 2; i++) begin
      if (got_q.size() > 0 && exp_q.size() > 0) begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        comps++; if (g !== e) begin errs++; $display("FAIL rmid_pre_word: got %h want %h", g, e); end
      end
    end
    exp_q.delete(); got_q.delete();
    h0 = hs_cnt; d0 = done_cnt;
    pulse_start();
    feed(NW, -1, 0, sb);
    push_tail();
    wait_done(d0);
    repeat (5) @(negedge clk);
    #1;
    comps++; if (hs_cnt - h0 !== NW) begin errs++; $display("FAIL rmid_hs: got %0d want %0d", hs_cnt - h0, NW); end
    comps++; if (got_q.size() !== exp_q.size()) begin errs++; $display("FAIL rmid_nwords: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      comps++; if (g !== e) begin errs++; $display("FAIL rmid_replay_word: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    comps++; if (result !== resp) begin errs++; $display("FAIL rmid_result_after: got %h want %h", result, resp); end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end

endmodule
